i2s_rx: RTL and testbench

I2S receive deserializer: oversamples an external `sclk`/`lrclk`/`sdi` stream in the framework `clk` domain, recovers 24-bit (by default) left/right samples, and writes each stereo pair into an asynchronous FIFO. It is the capture-side counterpart of `i2s_tx` and sits between the ADC/codec pins and the audio input FIFO. `clk` must be at least 4x `sclk`.

---
 rtl/i2s_rx.sv | 167 ++++++++++++++++
 tb/tb_i2s_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receive deserializer writing stereo pairs to a FIFO
// Optional input synchronizers: define I2S_RX_SYNC_EN.
module i2s_rx #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          lrclk,
    input  logic          sdi,
    input  logic          wr_full,
    output logic [DW-1:0] l_sample,
    output logic [DW-1:0] r_sample,
    output logic          wr_en,
    output logic          overflow,
    output logic          frame_err
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    logic sclk_s, lrclk_s, sdi_s;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] sclk_sync_q, lrclk_sync_q, sdi_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= 2'b00;
            lrclk_sync_q <= 2'b00;
            sdi_sync_q   <= 2'b00;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], sclk};
            lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
            sdi_sync_q   <= {sdi_sync_q[0], sdi};
        end
    end

    assign sclk_s  = sclk_sync_q[1];
    assign lrclk_s = lrclk_sync_q[1];
    assign sdi_s   = sdi_sync_q[1];
`else
    assign sclk_s  = sclk;
    assign lrclk_s = lrclk;
    assign sdi_s   = sdi;
`endif

    logic sclk_prev_q, lrclk_prev_q, armed_q;
    logic sclk_rise, lr_edge;

    // Prev registers track the pins even in reset so the first live cycle sees no false edge.
    always_ff @(posedge clk) begin
        sclk_prev_q  <= sclk_s;
        lrclk_prev_q <= lrclk_s;
        armed_q      <= ~rst;
    end

    assign sclk_rise = armed_q & sclk_s & ~sclk_prev_q;
    assign lr_edge   = armed_q & (lrclk_s != lrclk_prev_q);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic          chan_q, chan_d;
    logic [DW-1:0] left_hold_q;
    logic [DW-1:0] l_sample_q, r_sample_q;
    logic          wr_en_q, overflow_q, frame_err_q;
    logic          commit, short_word;
    logic [DW-1:0] word;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        chan_d     = chan_q;
        commit     = 1'b0;
        short_word = 1'b0;
        word       = shreg_q;
        case (state_q)
            IDLE: begin
                if (lr_edge && !lrclk_s) begin
                    chan_d  = 1'b0;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = sclk_rise ? SHIFT : DELAY;
                end
            end
            DELAY, SHIFT: begin
                if (lr_edge) begin
                    // Word cut short: commit what arrived, left-aligned with zero LSBs.
                    commit     = 1'b1;
                    short_word = 1'b1;
                    word       = shreg_q;
                    chan_d     = lrclk_s;
                    shreg_d    = '0;
                    cnt_d      = '0;
                    state_d    = sclk_rise ? SHIFT : DELAY;
                end else if (sclk_rise) begin
                    if (state_q == DELAY) begin
                        state_d = SHIFT;
                    end else begin
                        shreg_d[CW'(DW-1) - cnt_q] = sdi_s;
                        if (cnt_q == CW'(DW-1)) begin
                            commit  = 1'b1;
                            word    = shreg_d;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (lr_edge) begin
                    chan_d  = lrclk_s;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = sclk_rise ? SHIFT : DELAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            chan_q      <= 1'b0;
            left_hold_q <= '0;
            l_sample_q  <= '0;
            r_sample_q  <= '0;
            wr_en_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            chan_q      <= chan_d;
            wr_en_q     <= 1'b0;
            frame_err_q <= short_word;
            if (commit) begin
                if (!chan_q) begin
                    left_hold_q <= word;
                end else begin
                    l_sample_q <= left_hold_q;
                    r_sample_q <= word;
                    if (wr_full) overflow_q <= 1'b1;
                    else         wr_en_q    <= 1'b1;
                end
            end
        end
    end

    assign l_sample  = l_sample_q;
    assign r_sample  = r_sample_q;
    assign wr_en     = wr_en_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed and table-driven bench for i2s_rx
module tb_i2s_rx;
    localparam int DW = 24;
`ifdef I2S_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, lrclk = 1'b1, sdi = 1'b0, wr_full = 1'b0;
    logic [DW-1:0] l_sample, r_sample;
    logic wr_en, overflow, frame_err;

    i2s_rx #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdi(sdi), .wr_full(wr_full),
        .l_sample(l_sample), .r_sample(r_sample), .wr_en(wr_en),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int wr_tot = 0, ferr_tot = 0;
    int half = 4;
    bit jitter = 1'b0;
    int wr_snap, ferr_snap;

    always @(negedge clk) begin
        if (wr_en) wr_tot++;
        if (frame_err) ferr_tot++;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic lr, input logic d);
        if (jitter) half = $urandom_range(3, 6);
        sclk = 1'b0; lrclk = lr; sdi = d;
        tick(half);
        sclk = 1'b1;
        tick(half);
    endtask

    // Slot bit 0 is the delay slot, then ndata MSB-first bits, then junk ones.
    task automatic send_range(input logic lr, input logic [DW-1:0] w, input int ndata,
                              input int from, input int upto);
        logic b;
        for (int i = from; i < upto; i++) begin
            if (i == 0) b = 1'b1;
            else if (i - 1 < ndata) b = w[DW-i];
            else b = 1'b1;
            send_bit(lr, b);
        end
    endtask

    function automatic int slot_len(input int ndata, input int slot);
        return (ndata < DW) ? 1 + ndata : slot;
    endfunction

    typedef struct {
        logic [DW-1:0] l, r;
        int lbits, rbits, slot;
        logic full;
        logic [DW-1:0] el, er;
        int ewr, eferr;
        logic eovf;
    } vec_t;

    vec_t vt[6];

    task automatic check_window(input string tag, input logic [DW-1:0] el, input logic [DW-1:0] er,
                                input int ewr, input int eferr, input logic eovf);
        check({tag, "_wr"}, wr_tot - wr_snap, ewr);
        check({tag, "_ferr"}, ferr_tot - ferr_snap, eferr);
        check({tag, "_l"}, {8'h0, l_sample}, {8'h0, el});
        check({tag, "_r"}, {8'h0, r_sample}, {8'h0, er});
        check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, eovf});
    endtask

    initial begin
        vt[0] = '{24'hA5A5A5, 24'h5A5A5A, 24, 24, 25, 1'b0, 24'hA5A5A5, 24'h5A5A5A, 1, 0, 1'b0};
        vt[1] = '{24'h123456, 24'hABCDEF, 24, 24, 32, 1'b0, 24'h123456, 24'hABCDEF, 1, 0, 1'b0};
        vt[2] = '{24'h0F0F0F, 24'hFFFFFF, 24, 16, 25, 1'b0, 24'h0F0F0F, 24'hFFFF00, 1, 1, 1'b0};
        vt[3] = '{24'h111111, 24'h222222, 24, 24, 25, 1'b1, 24'h111111, 24'h222222, 0, 0, 1'b1};
        vt[4] = '{24'h800001, 24'h7FFFFE, 24, 24, 28, 1'b0, 24'h800001, 24'h7FFFFE, 1, 0, 1'b1};
        vt[5] = '{24'hFFFFFF, 24'h000001, 8, 24, 25, 1'b0, 24'hFF0000, 24'h000001, 1, 1, 1'b1};

        tick(3);
        @(negedge clk);
        check("rst_l", {8'h0, l_sample}, 32'h0);
        check("rst_r", {8'h0, r_sample}, 32'h0);
        check("rst_wr", {31'h0, wr_en}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(4);

        for (int k = 0; k < 6; k++) begin
            send_range(1'b0, vt[k].l, vt[k].lbits, 0, 1);
            if (k > 0)
                check_window($sformatf("vec%0d", k - 1), vt[k-1].el, vt[k-1].er,
                             vt[k-1].ewr, vt[k-1].eferr, vt[k-1].eovf);
            wr_snap = wr_tot; ferr_snap = ferr_tot;
            send_range(1'b0, vt[k].l, vt[k].lbits, 1, slot_len(vt[k].lbits, vt[k].slot));
            wr_full = vt[k].full;
            send_range(1'b1, vt[k].r, vt[k].rbits, 0, slot_len(vt[k].rbits, vt[k].slot));
            wr_full = 1'b0;
        end
        send_range(1'b0, 24'h3C3C3C, 24, 0, 1);
        check_window("vec5", vt[5].el, vt[5].er, vt[5].ewr, vt[5].eferr, vt[5].eovf);

        // wr_en latency from the rising sclk carrying the right LSB
        send_range(1'b0, 24'h3C3C3C, 24, 1, 25);
        send_range(1'b1, 24'hC3C3C3, 24, 0, 24);
        sclk = 1'b0; lrclk = 1'b1; sdi = 1'b1;
        tick(half);
        sclk = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("lat_wr_hi", {31'h0, wr_en}, 32'h1);
        check("lat_r", {8'h0, r_sample}, 32'h00C3C3C3);
        check("lat_l", {8'h0, l_sample}, 32'h003C3C3C);
        @(negedge clk);
        check("lat_wr_lo", {31'h0, wr_en}, 32'h0);
        tick(4);

        // reset in the middle of a right slot
        send_range(1'b0, 24'hAAAAAA, 24, 0, 25);
        send_range(1'b1, 24'h555555, 24, 0, 10);
        rst = 1'b1;
        tick(2);
        check("mid_rst_ovf", {31'h0, overflow}, 32'h0);
        check("mid_rst_r", {8'h0, r_sample}, 32'h0);
        rst = 1'b0;
        wr_snap = wr_tot; ferr_snap = ferr_tot;
        send_range(1'b1, 24'h555555, 24, 10, 25);
        tick(6);
        check("mid_rst_nowr", wr_tot - wr_snap, 0);
        send_range(1'b0, 24'hC0FFEE, 24, 0, 1);
        wr_snap = wr_tot; ferr_snap = ferr_tot;
        send_range(1'b0, 24'hC0FFEE, 24, 1, 25);
        send_range(1'b1, 24'hBADCAF, 24, 0, 25);
        send_range(1'b0, 24'h0, 24, 0, 1);
        check_window("post_rst", 24'hC0FFEE, 24'hBADCAF, 1, 0, 1'b0);

        // random pairs with jittered sclk half-periods
        jitter = 1'b1;
        for (int p = 0; p < 30; p++) begin
            logic [DW-1:0] lw, rw;
            lw = DW'($urandom);
            rw = DW'($urandom);
            send_range(1'b0, lw, 24, 1, 25);
            wr_snap = wr_tot;
            send_range(1'b1, rw, 24, 0, 25);
            send_range(1'b0, 24'h0, 24, 0, 1);
            check($sformatf("rnd%0d_wr", p), wr_tot - wr_snap, 1);
            check($sformatf("rnd%0d_lr", p), {8'h0, l_sample ^ r_sample}, {8'h0, lw ^ rw});
            check($sformatf("rnd%0d_l", p), {8'h0, l_sample}, {8'h0, lw});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
